frame_reader: RTL and testbench

Read-side counterpart of the camera write path. It scans the 240×320 portrait frame buffer (16-bit RGB565, 76 800 entries, address = row·240 + col) in raster order, driven by the display's hcount/vcount. It issues BRAM read addresses and re-aligns the returned pixels with delayed display coordinates. It sits between the frame-buffer BRAM read port and the display pixel mux, with optional integer upscaling.

---
 rtl/frame_reader.sv | 114 +++++++++++
 tb/tb_frame_reader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader.sv
// frame_reader: raster-scans a 240x320 RGB565 frame buffer with integer upscaling and re-aligns BRAM data to display coordinates
module frame_reader #(
  parameter int X_OFFSET = 0,
  parameter int Y_OFFSET = 0,
  parameter int SCALE = 2,
  parameter int READ_LATENCY = 2,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic [16:0] pixel_addr_out,
  input  logic [15:0] pixel_data_in,
  output logic [15:0] pixel_out,
  output logic        in_frame_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out
);
  localparam int D = READ_LATENCY + 1;
  localparam logic [11:0] X0 = 12'(X_OFFSET);
  localparam logic [11:0] X1 = 12'(X_OFFSET + 240 * SCALE);
  localparam logic [11:0] Y0 = 12'(Y_OFFSET);
  localparam logic [11:0] Y1 = 12'(Y_OFFSET + 320 * SCALE);
  localparam logic [1:0] SM = 2'(SCALE - 1);
  logic [11:0] h, v;
  logic in_win, line_start;
  logic [1:0] hrep_q, hrep_d, vrep_q, vrep_d;
  logic [16:0] row_base_q, row_base_d, addr_q, addr_d;
  logic synced_q, synced_d;
  logic [10:0] hp_q [D];
  logic [10:0] hp_d [D];
  logic [9:0] vp_q [D];
  logic [9:0] vp_d [D];
  logic [D-1:0] vld_q, vld_d;
  logic [15:0] pix_q, pix_d;
  logic in_frame_q, in_frame_d;
  logic [10:0] hout_q, hout_d;
  logic [9:0] vout_q, vout_d;
  assign h = {1'b0, hcount_in};
  assign v = {2'b00, vcount_in};
  assign in_win = h >= X0 && h < X1 && v >= Y0 && v < Y1;
  assign line_start = in_win && h == X0;
  // counters advance only on in-window samples; line and frame starts are found by compare alone
  always_comb begin
    hrep_d = hrep_q;
    vrep_d = vrep_q;
    row_base_d = row_base_q;
    addr_d = addr_q;
    synced_d = synced_q;
    if (line_start) begin
      hrep_d = 2'd0;
      if (v == Y0) begin
        row_base_d = 17'd0;
        vrep_d = 2'd0;
        synced_d = 1'b1;
      end else begin
        row_base_d = vrep_q == SM ? row_base_q + 17'd240 : row_base_q;
        vrep_d = vrep_q == SM ? 2'd0 : vrep_q + 2'd1;
      end
      addr_d = row_base_d;
    end else if (in_win) begin
      hrep_d = hrep_q == SM ? 2'd0 : hrep_q + 2'd1;
      addr_d = hrep_q == SM ? addr_q + 17'd1 : addr_q;
    end
  end
  always_comb begin
    hp_d[0] = hcount_in;
    vp_d[0] = vcount_in;
    for (int i = 1; i < D; i++) begin
      hp_d[i] = hp_q[i-1];
      vp_d[i] = vp_q[i-1];
    end
    vld_d = {vld_q[D-2:0], in_win & synced_d};
    in_frame_d = vld_q[D-1];
    pix_d = vld_q[D-1] ? pixel_data_in : BG_COLOR;
    hout_d = hp_q[D-1];
    vout_d = vp_q[D-1];
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hrep_q <= '0;
      vrep_q <= '0;
      row_base_q <= '0;
      addr_q <= '0;
      synced_q <= 1'b0;
      hp_q <= '{default: '0};
      vp_q <= '{default: '0};
      vld_q <= '0;
      pix_q <= BG_COLOR;
      in_frame_q <= 1'b0;
      hout_q <= '0;
      vout_q <= '0;
    end else begin
      hrep_q <= hrep_d;
      vrep_q <= vrep_d;
      row_base_q <= row_base_d;
      addr_q <= addr_d;
      synced_q <= synced_d;
      hp_q <= hp_d;
      vp_q <= vp_d;
      vld_q <= vld_d;
      pix_q <= pix_d;
      in_frame_q <= in_frame_d;
      hout_q <= hout_d;
      vout_q <= vout_d;
    end
  end
  assign pixel_addr_out = addr_q;
  assign pixel_out = pix_q;
  assign in_frame_out = in_frame_q;
  assign hcount_out = hout_q;
  assign vcount_out = vout_q;
endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: five frame_reader variants against a formula-based reference model with random frame-buffer contents
module tb_frame_reader;
  localparam int N = 65536;
  localparam int PX [5] = '{0, 100, 0, 100, 100};
  localparam int PY [5] = '{0, 50, 0, 50, 50};
  localparam int PS [5] = '{1, 2, 3, 2, 2};
  localparam int PL [5] = '{2, 2, 2, 1, 3};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic [16:0] addr_o [5];
  logic [15:0] din [5];
  logic [15:0] pix_o [5];
  logic inf_o [5];
  logic [10:0] ho [5];
  logic [9:0] vo [5];
  logic [15:0] mem [76800];
  logic [15:0] bp [5][3];
  int hh [N];
  int vv [N];
  bit rr [N];
  bit syh [5][N];
  bit sy [5];
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  frame_reader #(.X_OFFSET(0), .Y_OFFSET(0), .SCALE(1), .READ_LATENCY(2)) u_a (.clk_in(clk), .rst_in(rst),
    .hcount_in(hcount), .vcount_in(vcount), .pixel_addr_out(addr_o[0]), .pixel_data_in(din[0]),
    .pixel_out(pix_o[0]), .in_frame_out(inf_o[0]), .hcount_out(ho[0]), .vcount_out(vo[0]));
  frame_reader #(.X_OFFSET(100), .Y_OFFSET(50), .SCALE(2), .READ_LATENCY(2)) u_b (.clk_in(clk), .rst_in(rst),
    .hcount_in(hcount), .vcount_in(vcount), .pixel_addr_out(addr_o[1]), .pixel_data_in(din[1]),
    .pixel_out(pix_o[1]), .in_frame_out(inf_o[1]), .hcount_out(ho[1]), .vcount_out(vo[1]));
  frame_reader #(.X_OFFSET(0), .Y_OFFSET(0), .SCALE(3), .READ_LATENCY(2)) u_c (.clk_in(clk), .rst_in(rst),
    .hcount_in(hcount), .vcount_in(vcount), .pixel_addr_out(addr_o[2]), .pixel_data_in(din[2]),
    .pixel_out(pix_o[2]), .in_frame_out(inf_o[2]), .hcount_out(ho[2]), .vcount_out(vo[2]));
  frame_reader #(.X_OFFSET(100), .Y_OFFSET(50), .SCALE(2), .READ_LATENCY(1)) u_l1 (.clk_in(clk), .rst_in(rst),
    .hcount_in(hcount), .vcount_in(vcount), .pixel_addr_out(addr_o[3]), .pixel_data_in(din[3]),
    .pixel_out(pix_o[3]), .in_frame_out(inf_o[3]), .hcount_out(ho[3]), .vcount_out(vo[3]));
  frame_reader #(.X_OFFSET(100), .Y_OFFSET(50), .SCALE(2), .READ_LATENCY(3)) u_l3 (.clk_in(clk), .rst_in(rst),
    .hcount_in(hcount), .vcount_in(vcount), .pixel_addr_out(addr_o[4]), .pixel_data_in(din[4]),
    .pixel_out(pix_o[4]), .in_frame_out(inf_o[4]), .hcount_out(ho[4]), .vcount_out(vo[4]));

  function automatic logic [15:0] rd(input logic [16:0] a);
    if (a < 17'd76800) return mem[a];
    return 16'hDEAD;
  endfunction

  function automatic bit win(input int k, input int h, input int v);
    return h >= PX[k] && h < PX[k] + 240 * PS[k] && v >= PY[k] && v < PY[k] + 320 * PS[k];
  endfunction

  function automatic int faddr(input int k, input int h, input int v);
    return ((v - PY[k]) / PS[k]) * 240 + (h - PX[k]) / PS[k];
  endfunction

  function automatic bit nsy(input int k);
    if (rst) return 1'b0;
    if (int'(hcount) == PX[k] && int'(vcount) == PY[k]) return 1'b1;
    return sy[k];
  endfunction

  function automatic int spot(input int k, input int h, input int v);
    if (PX[k] != 100) return -1;
    if (h == 100 && v == 50) return 0;
    if (h == 101 && v == 51) return 0;
    if (h == 102 && v == 50) return 1;
    if (h == 100 && v == 52) return 240;
    if (h == 579 && v == 689) return 76799;
    return -1;
  endfunction

  // Output after edge e describes the sample of edge e-L-1, unless a reset edge lies in between.
  function automatic void model_out(input int k, input int e, output logic [10:0] eh, output logic [9:0] ev,
                                    output logic ef, output logic [15:0] ep);
    int s;
    bit rs;
    s = e - PL[k] - 1;
    rs = s < 0;
    eh = '0;
    ev = '0;
    ef = 1'b0;
    ep = 16'h0000;
    if (!rs) for (int i = s; i <= e; i++) if (rr[i]) rs = 1'b1;
    if (!rs) begin
      eh = 11'(hh[s]);
      ev = 10'(vv[s]);
      ef = win(k, hh[s], vv[s]) && syh[k][s];
      ep = ef ? rd(17'(faddr(k, hh[s], vv[s]))) : 16'h0000;
    end
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) begin
      bp[k][0] <= rd(addr_o[k]);
      bp[k][1] <= bp[k][0];
      bp[k][2] <= bp[k][1];
    end
  end

  always_comb for (int k = 0; k < 5; k++) din[k] = bp[k][PL[k]-1];

  always @(posedge clk) begin
    if (cyc < N) begin
      hh[cyc] <= int'(hcount);
      vv[cyc] <= int'(vcount);
      rr[cyc] <= rst;
      for (int k = 0; k < 5; k++) syh[k][cyc] <= nsy(k);
    end
    for (int k = 0; k < 5; k++) sy[k] <= nsy(k);
    cyc <= cyc + 1;
  end

  task automatic drive(input int h, input int v);
    hcount = 11'(h);
    vcount = 10'(v);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input int g, input int v0, input int v1, input bit [4:0] chk, input bit full_rows,
                           input bit no_frame);
    int hq [$];
    int e, sp, hs, he;
    bit full;
    logic [10:0] eh;
    logic [9:0] ev;
    logic ef;
    logic [15:0] ep;
    for (int v = v0; v <= v1; v++) begin
      full = full_rows && v >= PY[g] && (v - PY[g] < 3 || (v - PY[g] >= 320 * PS[g] - 2 && v - PY[g] < 320 * PS[g]));
      hs = full ? PX[g] - 2 : PX[g] - 1;
      he = full ? PX[g] + 240 * PS[g] + 1 : PX[g] + int'($urandom_range(0, 9));
      hq = {};
      for (int h = hs; h <= he; h++) if (h >= 0) hq.push_back(h);
      if ($urandom_range(0, 3) == 0) hq.push_back(1000 + int'($urandom_range(0, 23)));
      foreach (hq[i]) begin
        drive(hq[i], v);
        e = cyc - 1;
        for (int k = 0; k < 5; k++) if (chk[k]) begin
          model_out(k, e, eh, ev, ef, ep);
          nvec++;
          if (inf_o[k] !== ef) begin
            nerr++;
            $display("FAIL in_frame k=%0d h=%0d v=%0d got %b want %b", k, hh[e], vv[e], inf_o[k], ef);
          end
          if (pix_o[k] !== ep) begin
            nerr++;
            $display("FAIL pixel k=%0d h=%0d v=%0d got %h want %h", k, hh[e], vv[e], pix_o[k], ep);
          end
          if (ho[k] !== eh || vo[k] !== ev) begin
            nerr++;
            $display("FAIL coords k=%0d got %0d,%0d want %0d,%0d", k, ho[k], vo[k], eh, ev);
          end
          if (no_frame && inf_o[k] !== 1'b0) begin
            nerr++;
            $display("FAIL in_frame_after_reset k=%0d got %b want 0", k, inf_o[k]);
          end
          if (syh[k][e] && win(k, hh[e], vv[e]) && addr_o[k] !== 17'(faddr(k, hh[e], vv[e]))) begin
            nerr++;
            $display("FAIL addr k=%0d h=%0d v=%0d got %0d want %0d", k, hh[e], vv[e], addr_o[k], faddr(k, hh[e], vv[e]));
          end
          sp = spot(k, hh[e], vv[e]);
          if (syh[k][e] && sp >= 0 && addr_o[k] !== 17'(sp)) begin
            nerr++;
            $display("FAIL spot_addr k=%0d h=%0d v=%0d got %0d want %0d", k, hh[e], vv[e], addr_o[k], sp);
          end
          if (syh[k][e] && addr_o[k] > 17'd76799) begin
            nerr++;
            $display("FAIL addr_range k=%0d got %0d want <=76799", k, addr_o[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) drive(7, 9);
    for (int k = 0; k < 5; k++) begin
      nvec++;
      if (addr_o[k] !== 17'd0 || pix_o[k] !== 16'h0000 || inf_o[k] !== 1'b0 || ho[k] !== 11'd0 || vo[k] !== 10'd0) begin
        nerr++;
        $display("FAIL reset_state k=%0d got addr=%0d pix=%h inf=%b h=%0d v=%0d want all 0", k, addr_o[k], pix_o[k],
                 inf_o[k], ho[k], vo[k]);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(7, 9);
      for (int k = 0; k < 5; k++) begin
        nvec++;
        if (ho[k] !== 11'(i >= PL[k] + 1 ? 7 : 0) || vo[k] !== 10'(i >= PL[k] + 1 ? 9 : 0) || inf_o[k] !== 1'b0 ||
            pix_o[k] !== 16'h0000) begin
          nerr++;
          $display("FAIL reset_flush k=%0d i=%0d got h=%0d v=%0d inf=%b pix=%h want h=%0d v=%0d inf=0 pix=0", k, i, ho[k],
                   vo[k], inf_o[k], pix_o[k], i >= PL[k] + 1 ? 7 : 0, i >= PL[k] + 1 ? 9 : 0);
        end
      end
    end
  endtask

  task automatic test_scale();
    int cnt [3];
    cnt = '{0, 0, 0};
    for (int v = 0; v < 4; v++) for (int h = 0; h < 9; h++) begin
      drive(h, v);
      if (v == 3) begin
        nvec++;
        if (addr_o[0] !== 17'(720 + h)) begin
          nerr++;
          $display("FAIL scale1_addr h=%0d got %0d want %0d", h, addr_o[0], 720 + h);
        end
        if (h == 0 && addr_o[2] !== 17'd240) begin
          nerr++;
          $display("FAIL scale3_line_start got %0d want 240", addr_o[2]);
        end
        if (addr_o[2] >= 17'd240 && addr_o[2] <= 17'd242) cnt[addr_o[2] - 17'd240]++;
        else begin
          nerr++;
          $display("FAIL scale3_addr h=%0d got %0d want 240..242", h, addr_o[2]);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (cnt[i] != 3) begin
        nerr++;
        $display("FAIL scale3_repeat addr=%0d got %0d samples want 3", 240 + i, cnt[i]);
      end
    end
  endtask

  task automatic test_single_pixel();
    for (int v = 0; v < 4; v++) for (int h = 0; h <= (v == 3 ? 5 : 8); h++) drive(h, v);
    nvec++;
    if (addr_o[0] !== 17'd725) begin
      nerr++;
      $display("FAIL single_addr got %0d want 725", addr_o[0]);
    end
    repeat (3) drive(900, 3);
    nvec++;
    if (pix_o[0] !== mem[725] || inf_o[0] !== 1'b1 || ho[0] !== 11'd5 || vo[0] !== 10'd3) begin
      nerr++;
      $display("FAIL single_out got pix=%h inf=%b h=%0d v=%0d want pix=%h inf=1 h=5 v=3", pix_o[0], inf_o[0], ho[0],
               vo[0], mem[725]);
    end
  endtask

  task automatic test_window_edges();
    int hs [7] = '{99, 100, 580, 0, 0, 0, 0};
    int vs [7] = '{50, 50, 50, 0, 0, 0, 0};
    logic ef [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] ep [3];
    ep = '{16'h0000, mem[0], 16'h0000};
    for (int i = 0; i < 6; i++) begin
      drive(hs[i], vs[i]);
      if (i >= 3) begin
        nvec++;
        if (inf_o[1] !== ef[i-3] || pix_o[1] !== ep[i-3] || ho[1] !== 11'(hs[i-3]) || vo[1] !== 10'(vs[i-3])) begin
          nerr++;
          $display("FAIL window_edge h=%0d got inf=%b pix=%h at %0d,%0d want inf=%b pix=%h", hs[i-3], inf_o[1], pix_o[1],
                   ho[1], vo[1], ef[i-3], ep[i-3]);
        end
      end
    end
  endtask

  task automatic test_latency();
    int j;
    for (int i = 0; i < 36; i++) begin
      drive(100 + i, 50);
      for (int k = 1; k < 5; k++) if (k != 2 && i >= PL[k] + 1) begin
        j = i - PL[k] - 1;
        nvec++;
        if (ho[k] !== 11'(100 + j) || vo[k] !== 10'd50 || inf_o[k] !== 1'b1 || pix_o[k] !== mem[j/2]) begin
          nerr++;
          $display("FAIL latency k=%0d L=%0d got h=%0d v=%0d inf=%b pix=%h want h=%0d v=50 inf=1 pix=%h", k, PL[k], ho[k],
                   vo[k], inf_o[k], pix_o[k], 100 + j, mem[j/2]);
        end
      end
    end
  endtask

  task automatic test_full_scan();
    run_frame(1, 49, 690, 5'b11010, 1'b1, 1'b0);
  endtask

  task automatic test_mid_frame_reset();
    run_frame(1, 49, 199, 5'b00010, 1'b0, 1'b0);
    rst = 1'b1;
    drive(50, 200);
    rst = 1'b0;
    nvec++;
    if (addr_o[1] !== 17'd0 || pix_o[1] !== 16'h0000 || inf_o[1] !== 1'b0 || ho[1] !== 11'd0 || vo[1] !== 10'd0) begin
      nerr++;
      $display("FAIL mid_reset got addr=%0d pix=%h inf=%b h=%0d v=%0d want all 0", addr_o[1], pix_o[1], inf_o[1], ho[1],
               vo[1]);
    end
    run_frame(1, 200, 690, 5'b00010, 1'b0, 1'b1);
    run_frame(1, 49, 120, 5'b00010, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 76800; i++) mem[i] = 16'($urandom);
    test_reset();
    test_scale();
    test_single_pixel();
    test_window_edges();
    test_latency();
    test_full_scan();
    test_mid_frame_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
